// File: rtl/pwm_regs_pkg.sv
// Shared constants for the multi-channel PWM register file: address map,
// CTRL bit positions, reset values and byte-lane helpers.
package pwm_regs_pkg;

    localparam logic [7:0] ID_VALUE  = 8'hA1;
    localparam logic [7:0] CH_STRIDE = 8'h20;

    // Global page (addr[ADDR_W-1:5] == 0) register offsets
    localparam logic [4:0] ADDR_ID     = 5'h00;
    localparam logic [4:0] ADDR_COMMIT = 5'h01;
    localparam logic [4:0] ADDR_IRQ_EN = 5'h02;

    // Channel page: offset[4:2] selects a 4-byte field
    typedef enum logic [2:0] {
        FLD_PERIOD  = 3'd0,
        FLD_CMP1    = 3'd1,
        FLD_CMP2    = 3'd2,
        FLD_COUNTER = 3'd3,
        FLD_MISC    = 3'd4
    } ch_field_e;

    // Byte lanes within FLD_MISC (offsets 0x10..0x13)
    localparam logic [1:0] MISC_CTRL      = 2'd0;
    localparam logic [1:0] MISC_PRESCALE  = 2'd1;
    localparam logic [1:0] MISC_FUNCTIONS = 2'd2;
    localparam logic [1:0] MISC_STATUS    = 2'd3;

    localparam int CTRL_EN             = 0;
    localparam int CTRL_UPNOTDOWN      = 1;
    localparam int CTRL_PWM_EN         = 2;
    localparam int CTRL_COUNT_RESET    = 3;
    localparam int CTRL_COMMIT_PENDING = 4;

    localparam logic RST_UPNOTDOWN = 1'b1;

    function automatic logic [7:0] get_byte(logic [31:0] v, logic [1:0] idx, int nb);
        logic [7:0] r;
        r = '0;
        if (int'(idx) < nb) r = v[idx*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] put_byte(logic [31:0] v, logic [1:0] idx,
                                             logic [7:0] b, int nb);
        logic [31:0] r;
        r = v;
        if (int'(idx) < nb) r[idx*8 +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/pwm_regs_mc_if.sv
// Byte-wide register bus between the SPI/bus decoder and pwm_regs_mc.
interface pwm_regs_mc_if #(
    parameter int ADDR_W = 8
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_write;
    logic [7:0]        data_read;

    modport master (output read, write, addr, data_write, input data_read);
    modport slave  (input read, write, addr, data_write, output data_read);
endinterface

// File: rtl/pwm_regs_ch.sv
// One PWM channel's registers: period/compare (double-buffered when
// PWM_REGS_SHADOW_EN is defined), CTRL, counter snapshot, W1C status.
module pwm_regs_ch
    import pwm_regs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             read,
    input  logic             write,
    input  logic [4:0]       off,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    input  logic             commit_set,
    input  logic [CNT_W-1:0] counter_val,
    input  logic             wrap,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] compare1,
    output logic [CNT_W-1:0] compare2,
    output logic             en,
    output logic             upnotdown,
    output logic             pwm_en,
    output logic             count_reset,
    output logic [7:0]       prescale,
    output logic [7:0]       functions,
    output logic             wrap_seen
);

    localparam int NB = CNT_W / 8;

    logic [2:0] fld;
    logic [1:0] bsel;
    logic       wr, wr_period, wr_cmp1, wr_cmp2, wr_ctrl, wr_pre, wr_fun, wr_status;
    logic       rd_snap;

    assign fld       = off[4:2];
    assign bsel      = off[1:0];
    assign wr        = sel & write;
    assign wr_period = wr & (fld == FLD_PERIOD);
    assign wr_cmp1   = wr & (fld == FLD_CMP1);
    assign wr_cmp2   = wr & (fld == FLD_CMP2);
    assign wr_ctrl   = wr & (fld == FLD_MISC) & (bsel == MISC_CTRL);
    assign wr_pre    = wr & (fld == FLD_MISC) & (bsel == MISC_PRESCALE);
    assign wr_fun    = wr & (fld == FLD_MISC) & (bsel == MISC_FUNCTIONS);
    assign wr_status = wr & (fld == FLD_MISC) & (bsel == MISC_STATUS);
    assign rd_snap   = sel & read & (fld == FLD_COUNTER) & (bsel == 2'd0);

    logic             commit_pending;
    logic [CNT_W-1:0] period_rd, cmp1_rd, cmp2_rd;

`ifdef PWM_REGS_SHADOW_EN
    logic [CNT_W-1:0] period_sh, cmp1_sh, cmp2_sh;
    logic             transfer;

    // Active follows shadow continuously while the counter is stopped.
    assign transfer  = (commit_pending & wrap) | ~en;
    assign period_rd = period_sh;
    assign cmp1_rd   = cmp1_sh;
    assign cmp2_rd   = cmp2_sh;

    // NOTE: non-blocking assignments let a same-edge transfer see the pre-write shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_sh      <= '0;
            cmp1_sh        <= '0;
            cmp2_sh        <= '0;
            period         <= '0;
            compare1       <= '0;
            compare2       <= '0;
            commit_pending <= 1'b0;
        end else begin
            if (wr_period) period_sh <= CNT_W'(put_byte(32'(period_sh), bsel, wdata, NB));
            if (wr_cmp1)   cmp1_sh   <= CNT_W'(put_byte(32'(cmp1_sh), bsel, wdata, NB));
            if (wr_cmp2)   cmp2_sh   <= CNT_W'(put_byte(32'(cmp2_sh), bsel, wdata, NB));
            if (transfer) begin
                period   <= period_sh;
                compare1 <= cmp1_sh;
                compare2 <= cmp2_sh;
            end
            if (commit_set)    commit_pending <= 1'b1;
            else if (transfer) commit_pending <= 1'b0;
        end
    end
`else
    logic unused_commit_set;

    assign unused_commit_set = commit_set;
    assign commit_pending    = 1'b0;
    assign period_rd         = period;
    assign cmp1_rd           = compare1;
    assign cmp2_rd           = compare2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period   <= '0;
            compare1 <= '0;
            compare2 <= '0;
        end else begin
            if (wr_period) period   <= CNT_W'(put_byte(32'(period), bsel, wdata, NB));
            if (wr_cmp1)   compare1 <= CNT_W'(put_byte(32'(compare1), bsel, wdata, NB));
            if (wr_cmp2)   compare2 <= CNT_W'(put_byte(32'(compare2), bsel, wdata, NB));
        end
    end
`endif

    logic [CNT_W-1:0] snap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en          <= 1'b0;
            upnotdown   <= RST_UPNOTDOWN;
            pwm_en      <= 1'b0;
            count_reset <= 1'b0;
            prescale    <= '0;
            functions   <= '0;
            wrap_seen   <= 1'b0;
            snap        <= '0;
        end else begin
            count_reset <= wr_ctrl & wdata[CTRL_COUNT_RESET];
            if (wr_ctrl) begin
                en        <= wdata[CTRL_EN];
                upnotdown <= wdata[CTRL_UPNOTDOWN];
                pwm_en    <= wdata[CTRL_PWM_EN];
            end
            if (wr_pre) prescale  <= wdata;
            if (wr_fun) functions <= wdata;
            // A wrap in the same cycle as the clear keeps the bit set.
            wrap_seen <= wrap | (wrap_seen & ~(wr_status & wdata[0]));
            if (rd_snap) snap <= counter_val;
        end
    end

    logic [7:0] ctrl_rd;

    // NOTE: defaults first in every always_comb so no path infers a latch.
    always_comb begin
        ctrl_rd                      = '0;
        ctrl_rd[CTRL_EN]             = en;
        ctrl_rd[CTRL_UPNOTDOWN]      = upnotdown;
        ctrl_rd[CTRL_PWM_EN]         = pwm_en;
        ctrl_rd[CTRL_COMMIT_PENDING] = commit_pending;
    end

    always_comb begin
        rdata = '0;
        case (fld)
            FLD_PERIOD:  rdata = get_byte(32'(period_rd), bsel, NB);
            FLD_CMP1:    rdata = get_byte(32'(cmp1_rd), bsel, NB);
            FLD_CMP2:    rdata = get_byte(32'(cmp2_rd), bsel, NB);
            FLD_COUNTER: rdata = (bsel == 2'd0) ? counter_val[7:0]
                                                : get_byte(32'(snap), bsel, NB);
            FLD_MISC: begin
                case (bsel)
                    MISC_CTRL:      rdata = ctrl_rd;
                    MISC_PRESCALE:  rdata = prescale;
                    MISC_FUNCTIONS: rdata = functions;
                    default:        rdata = {7'b0, wrap_seen};
                endcase
            end
            default:     rdata = '0;
        endcase
    end

endmodule

// File: rtl/pwm_regs_mc.sv
// Multi-channel PWM register file: global ID/COMMIT/IRQ_EN, address decode,
// read mux and registered irq. Shadow buffering is enabled by PWM_REGS_SHADOW_EN.
module pwm_regs_mc
    import pwm_regs_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pwm_regs_mc_if.slave            bus,
    input  logic [NUM_CH*CNT_W-1:0] counter_val,
    input  logic [NUM_CH-1:0]       wrap,
    output logic [NUM_CH*CNT_W-1:0] period,
    output logic [NUM_CH*CNT_W-1:0] compare1,
    output logic [NUM_CH*CNT_W-1:0] compare2,
    output logic [NUM_CH-1:0]       en,
    output logic [NUM_CH-1:0]       upnotdown,
    output logic [NUM_CH-1:0]       pwm_en,
    output logic [NUM_CH-1:0]       count_reset,
    output logic [NUM_CH*8-1:0]     prescale,
    output logic [NUM_CH*8-1:0]     functions,
    output logic                    irq
);

    localparam int PW = ADDR_W - 5;

    logic [PW-1:0]     page;
    logic [4:0]        off;
    logic              glob_sel;
    logic              commit_set;
    logic [NUM_CH-1:0] irq_en;
    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] wrap_seen;
    logic [7:0]        ch_rdata [NUM_CH];

    // Channel k lives in 32-byte page k+1; page 0 holds the global registers.
    assign page       = bus.addr[ADDR_W-1:5];
    assign off        = bus.addr[4:0];
    assign glob_sel   = (page == '0);
    assign commit_set = bus.write & glob_sel & (off == ADDR_COMMIT) & bus.data_write[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            if (bus.write && glob_sel && off == ADDR_IRQ_EN) irq_en <= bus.data_write[NUM_CH-1:0];
            irq <= |(wrap_seen & irq_en);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_sel[k] = (page == PW'(k + 1));

        pwm_regs_ch #(.CNT_W(CNT_W)) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .sel         (ch_sel[k]),
            .read        (bus.read),
            .write       (bus.write),
            .off         (off),
            .wdata       (bus.data_write),
            .rdata       (ch_rdata[k]),
            .commit_set  (commit_set),
            .counter_val (counter_val[k*CNT_W +: CNT_W]),
            .wrap        (wrap[k]),
            .period      (period[k*CNT_W +: CNT_W]),
            .compare1    (compare1[k*CNT_W +: CNT_W]),
            .compare2    (compare2[k*CNT_W +: CNT_W]),
            .en          (en[k]),
            .upnotdown   (upnotdown[k]),
            .pwm_en      (pwm_en[k]),
            .count_reset (count_reset[k]),
            .prescale    (prescale[k*8 +: 8]),
            .functions   (functions[k*8 +: 8]),
            .wrap_seen   (wrap_seen[k])
        );
    end

    always_comb begin
        bus.data_read = '0;
        if (glob_sel) begin
            case (off)
                ADDR_ID:     bus.data_read = ID_VALUE;
                ADDR_IRQ_EN: bus.data_read = 8'(irq_en);
                default:     bus.data_read = '0;
            endcase
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_sel[k]) bus.data_read = ch_rdata[k];
        end
    end

endmodule

// File: tb/tb_pwm_regs_mc.sv
// Directed bench for pwm_regs_mc: register table plus hand-written
// sequences for commit, snapshot, pulse, W1C/irq and reset corners.
module tb_pwm_regs_mc;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int ADDR_W = 8;
`ifdef PWM_REGS_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH*CNT_W-1:0] counter_val;
    logic [NUM_CH-1:0]       wrap;
    logic [NUM_CH*CNT_W-1:0] period, compare1, compare2;
    logic [NUM_CH-1:0]       en, upnotdown, pwm_en, count_reset;
    logic [NUM_CH*8-1:0]     prescale, functions;
    logic                    irq;

    pwm_regs_mc_if #(.ADDR_W(ADDR_W)) bus ();

    pwm_regs_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .counter_val (counter_val),
        .wrap        (wrap),
        .period      (period),
        .compare1    (compare1),
        .compare2    (compare2),
        .en          (en),
        .upnotdown   (upnotdown),
        .pwm_en      (pwm_en),
        .count_reset (count_reset),
        .prescale    (prescale),
        .functions   (functions),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         is_write;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d,
                             input logic [NUM_CH-1:0] w = '0);
        @(negedge clk);
        bus.write = 1'b1; bus.addr = a; bus.data_write = d; wrap = w;
        @(negedge clk);
        bus.write = 1'b0; wrap = '0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.read = 1'b1; bus.addr = a;
        #1 d = bus.data_read;
        @(negedge clk);
        bus.read = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(name, 64'(d), 64'(exp));
    endtask

    task automatic pulse_wrap(input logic [NUM_CH-1:0] w);
        @(negedge clk); wrap = w;
        @(negedge clk); wrap = '0;
    endtask

    function automatic vec_t vw(logic [7:0] a, logic [7:0] d);
        vec_t v;
        v.is_write = 1'b1; v.addr = a; v.data = d; v.exp = '0;
        return v;
    endfunction

    function automatic vec_t vr(logic [7:0] a, logic [7:0] e);
        vec_t v;
        v.is_write = 1'b0; v.addr = a; v.data = '0; v.exp = e;
        return v;
    endfunction

    initial begin
        logic [7:0] d;

        vecs.push_back(vr(8'h00, 8'hA1));   // ID
        vecs.push_back(vr(8'h01, 8'h00));   // COMMIT reads 0
        vecs.push_back(vr(8'h02, 8'h00));   // IRQ_EN reset
        vecs.push_back(vr(8'h30, 8'h02));   // ch0 CTRL reset
        vecs.push_back(vr(8'h93, 8'h00));   // ch3 STATUS reset
        vecs.push_back(vw(8'h51, 8'h5A));   // ch1 PRESCALE
        vecs.push_back(vr(8'h51, 8'h5A));
        vecs.push_back(vw(8'h72, 8'hC3));   // ch2 FUNCTIONS
        vecs.push_back(vr(8'h72, 8'hC3));
        vecs.push_back(vw(8'h22, 8'h77));   // PERIOD byte 2 beyond CNT_W
        vecs.push_back(vr(8'h22, 8'h00));
        vecs.push_back(vw(8'h34, 8'hFF));   // unmapped channel offset
        vecs.push_back(vr(8'h34, 8'h00));
        vecs.push_back(vw(8'hA0, 8'hFF));   // page beyond NUM_CH
        vecs.push_back(vr(8'hA0, 8'h00));
        vecs.push_back(vw(8'h03, 8'hFF));   // unmapped global
        vecs.push_back(vr(8'h03, 8'h00));
        vecs.push_back(vw(8'h02, 8'hFF));   // IRQ_EN keeps NUM_CH bits
        vecs.push_back(vr(8'h02, 8'h0F));
        vecs.push_back(vw(8'h02, 8'h00));
        vecs.push_back(vw(8'h90, 8'h05));   // ch3 CTRL en+pwm_en
        vecs.push_back(vr(8'h90, 8'h05));

        rst_n = 1'b0;
        bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.data_write = '0;
        wrap = '0; counter_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        check("rst period", 64'(period), 64'h0);
        check("rst compare1", 64'(compare1), 64'h0);
        check("rst compare2", 64'(compare2), 64'h0);
        check("rst en", 64'(en), 64'h0);
        check("rst upnotdown", 64'(upnotdown), 64'hF);
        check("rst pwm_en", 64'(pwm_en), 64'h0);
        check("rst count_reset", 64'(count_reset), 64'h0);
        check("rst prescale", 64'(prescale), 64'h0);
        check("rst functions", 64'(functions), 64'h0);
        check("rst irq", 64'(irq), 64'h0);

        foreach (vecs[i]) begin
            if (vecs[i].is_write) bus_write(vecs[i].addr, vecs[i].data);
            else rd_check($sformatf("tbl%0d rd %02h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
        end
        check("prescale ch1", 64'(prescale[15:8]), 64'h5A);
        check("functions ch2", 64'(functions[23:16]), 64'hC3);
        check("en after ctrl", 64'(en), 64'h8);

        // en=0: active period follows shadow one cycle after the write
        bus_write(8'h20, 8'h34);
        bus_write(8'h21, 8'h12);
        check("period0 at write", 64'(period[15:0]), 64'(SHADOW ? 16'h0034 : 16'h1234));
        @(negedge clk);
        check("period0 next cycle", 64'(period[15:0]), 64'h1234);
        rd_check("period0 b0", 8'h20, 8'h34);
        rd_check("period0 b1", 8'h21, 8'h12);

        // en=1: CMP1 held until commit + wrap
        bus_write(8'h30, 8'h03);
        bus_write(8'h24, 8'h00);
        bus_write(8'h25, 8'h01);
        check("cmp1 before commit", 64'(compare1[15:0]), 64'(SHADOW ? 16'h0000 : 16'h0100));
        bus_write(8'h01, 8'h01);
        rd_check("ctrl0 pending", 8'h30, SHADOW ? 8'h13 : 8'h03);
        check("cmp1 awaiting wrap", 64'(compare1[15:0]), 64'(SHADOW ? 16'h0000 : 16'h0100));
        pulse_wrap(4'b0001);
        check("cmp1 after wrap", 64'(compare1[15:0]), 64'h0100);
        rd_check("ctrl0 pending clr", 8'h30, 8'h03);

        // COMMIT coinciding with a transfer leaves pending set
        bus_write(8'h01, 8'h01);
        bus_write(8'h01, 8'h01, 4'b0001);
        rd_check("ctrl0 commit+wrap", 8'h30, SHADOW ? 8'h13 : 8'h03);
        bus_write(8'h25, 8'h02);
        check("cmp1 hold", 64'(compare1[15:0]), 64'(SHADOW ? 16'h0100 : 16'h0200));
        // Shadow write coinciding with a transfer: active takes pre-write shadow
        bus_write(8'h24, 8'h55, 4'b0001);
        check("cmp1 write+wrap", 64'(compare1[15:0]), 64'(SHADOW ? 16'h0200 : 16'h0255));
        rd_check("cmp1 shadow b0", 8'h24, 8'h55);
        rd_check("ctrl0 after xfer", 8'h30, 8'h03);

        // Counter snapshot on ch1
        counter_val[31:16] = 16'hABCD;
        rd_check("cnt1 b0 live", 8'h4C, 8'hCD);
        counter_val[31:16] = 16'h0000;
        rd_check("cnt1 b1 snap", 8'h4D, 8'hAB);
        rd_check("cnt1 b2 beyond", 8'h4E, 8'h00);
        rd_check("cnt1 b0 live2", 8'h4C, 8'h00);

        // count_reset single and back-to-back pulses on ch2
        @(negedge clk);
        bus.write = 1'b1; bus.addr = 8'h70; bus.data_write = 8'h08;
        @(negedge clk) bus.write = 1'b0;
        @(posedge clk) #1;
        check("cnt_rst cleared", 64'(count_reset), 64'h0);
        @(negedge clk);
        bus.write = 1'b1;
        @(posedge clk) #1;
        check("cnt_rst b2b 1", 64'(count_reset), 64'h4);
        @(posedge clk) #1;
        check("cnt_rst b2b 2", 64'(count_reset), 64'h4);
        @(negedge clk) bus.write = 1'b0;
        @(posedge clk) #1;
        check("cnt_rst b2b end", 64'(count_reset), 64'h0);
        rd_check("ctrl2 reads 0", 8'h70, 8'h00);

        // Status W1C and irq
        bus_write(8'h33, 8'h01);
        rd_check("status0 cleared", 8'h33, 8'h00);
        bus_write(8'h02, 8'h01);
        @(negedge clk);
        check("irq idle", 64'(irq), 64'h0);
        wrap = 4'b0001;
        @(posedge clk) #1;
        check("irq lag", 64'(irq), 64'h0);
        @(negedge clk) wrap = '0;
        @(posedge clk) #1;
        check("irq set", 64'(irq), 64'h1);
        bus_write(8'h33, 8'h01, 4'b0001);
        rd_check("status0 w1c+wrap", 8'h33, 8'h01);
        check("irq held", 64'(irq), 64'h1);
        bus_write(8'h33, 8'h01);
        rd_check("status0 w1c", 8'h33, 8'h00);
        check("irq cleared", 64'(irq), 64'h0);
        pulse_wrap(4'b0010);
        @(negedge clk);
        check("irq masked ch1", 64'(irq), 64'h0);

        // Reset mid-pulse drops everything at once
        @(negedge clk);
        bus.write = 1'b1; bus.addr = 8'h70; bus.data_write = 8'h08;
        @(posedge clk) #1;
        check("pulse before rst", 64'(count_reset), 64'h4);
        rst_n = 1'b0;
        #1;
        check("rst count_reset", 64'(count_reset), 64'h0);
        check("rst period mid", 64'(period), 64'h0);
        check("rst upnotdown mid", 64'(upnotdown), 64'hF);
        check("rst irq mid", 64'(irq), 64'h0);
        bus.write = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        rd_check("rst irq_en", 8'h02, 8'h00);
        rd_check("rst cmp1 b1", 8'h25, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_regs_mc.md
Name: pwm_regs_mc

Overview:
- Multi-channel, parametrised successor to the single-channel PWM register file.
- Sits between the SPI/bus decoder and NUM_CH counter+PWM channel pairs.
- Adds double-buffered (shadow/active) period and compare registers, committed on each channel's counter wrap.
- Adds a coherent multi-byte counter snapshot, self-clearing count_reset pulses, sticky W1C wrap status and a masked interrupt.

Parameters:
- NUM_CH, 4, number of PWM channels, 1..7.
- CNT_W, 16, counter/period/compare width; one of 8, 16, 24, 32.
- ADDR_W, 8, decoder address width.

Ports:
- clk  in  1  peripheral clock
- rst_n  in  1  reset
- read  in  1  read strobe from decoder
- write  in  1  write strobe from decoder
- addr  in  ADDR_W  byte address
- data_write  in  8  write data
- data_read  out  8  read data, combinational from addr
- counter_val  in  NUM_CH*CNT_W  live counter values, channel k at [k*CNT_W +: CNT_W]
- wrap  in  NUM_CH  one-cycle pulse per channel at counter period boundary
- period  out  NUM_CH*CNT_W  active period
- compare1  out  NUM_CH*CNT_W  active compare1
- compare2  out  NUM_CH*CNT_W  active compare2
- en  out  NUM_CH  counter enable
- upnotdown  out  NUM_CH  count direction
- pwm_en  out  NUM_CH  PWM output enable
- count_reset  out  NUM_CH  one-cycle counter reset pulse
- prescale  out  NUM_CH*8  prescaler
- functions  out  NUM_CH*8  PWM function select
- irq  out  1  OR of (status & irq_en) across channels

Reset and clock: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Global map:
  - 0x00 ID: RO, 0xA1.
  - 0x01 COMMIT: write bit0=1 sets commit_pending for all channels; reads 0.
  - 0x02 IRQ_EN: RW, bits[NUM_CH-1:0].
- Channel k base: 0x20*(k+1).
  - +0x00..03 PERIOD shadow.
  - +0x04..07 CMP1 shadow.
  - +0x08..0B CMP2 shadow.
  - +0x0C..0F COUNTER: RO.
  - +0x10 CTRL: bit0 en, bit1 upnotdown, bit2 pwm_en, bit3 count_reset (write-only, reads 0), bit4 commit_pending (RO).
  - +0x11 PRESCALE.
  - +0x12 FUNCTIONS.
  - +0x13 STATUS: bit0 wrap_seen, W1C.
- Multi-byte fields are little-endian. Bytes at or above CNT_W/8 read 0 and ignore writes. Unmapped addresses read 0 and ignore writes.
- Reset values: all registers 0 except upnotdown=1. Shadow=active=0, commit_pending=0, irq_en=0, status=0, count_reset=0, irq=0.
- Writes take effect on the posedge where write=1. Reads have zero latency.
- Shadow transfer: active <= shadow for PERIOD/CMP1/CMP2 when commit_pending & wrap[k], or every cycle while en[k]=0 (active tracks shadow one cycle after a write). commit_pending[k] clears on transfer.
- Shadow write in the same cycle as a transfer: active takes the pre-write shadow value; the new byte lands in shadow.
- COMMIT write in the same cycle as a transfer: the transfer occurs and pending remains 1 (set wins).
- count_reset: CTRL write with bit3=1 asserts count_reset[k] for exactly the next cycle, then clears. Back-to-back writes give back-to-back pulses.
- Counter snapshot:
  - Reading COUNTER byte0 returns live counter_val[7:0] and latches the full value into snap[k] at that posedge.
  - Bytes 1..3 return snap[k].
- Status: wrap[k] sets wrap_seen. A W1C write in the same cycle as wrap leaves it set.
- irq is registered, updated one cycle after a status or irq_en change.
- Reset mid-operation: everything returns to reset values immediately; any in-flight pulse is dropped.

Optional Feature:
- Macro: PWM_REGS_SHADOW_EN.
- Defined: double buffering as above.
- Undefined: PERIOD/CMP writes go directly to active. COMMIT is a no-op, commit_pending reads 0, and shadow storage is not synthesised.

Decomposition:
- Package pwm_regs_pkg: address offsets, CH_STRIDE=0x20, ID value, CTRL bit indices, reset constants.
- One sub-module, pwm_regs_ch: per-channel registers, shadow, snapshot, status and pulse logic. Instantiated NUM_CH times by generate.
- The top level holds the global regs, address decode, read mux and irq.

Test Plan:
- Reset, then read 0x00 -> 0xA1; read ch0 CTRL (0x30) -> 0x02; all outputs at reset values; irq=0.
- en=0: write 0x20=0x34, 0x21=0x12 -> period[ch0]=0x1234 one cycle after the second write.
- en=1: write CMP1=0x0100, then COMMIT -> compare1 unchanged until wrap[0] pulses, then 0x0100; CTRL bit4 goes 1 -> 0.
- counter_val ch1=0xABCD: read 0x4C -> 0xCD; change counter to 0x0000; read 0x4D -> 0xAB.
- Write ch2 CTRL=0x08 -> count_reset[2] high exactly 1 cycle; CTRL reads 0x00.
- IRQ_EN=0x01; pulse wrap[0] -> irq=1 next cycle; W1C 0x33=0x01 together with wrap[0] -> status stays 1; later W1C -> irq=0.
